// File: rtl/lfu_victim_select.sv
// lfu_victim_select
// Replacement controller for a set-associative cache backed by an LFU counter
// array with a registered read port. Hits increment the counter of the hit
// line. A miss scans every way of the set, picks the least-frequently-used way
// (lowest index wins on a tie), clears that way's counter and reports it as
// the victim. The scan takes WAYS read cycles, one drain cycle and one
// replace cycle, so the victim is reported WAYS+2 cycles after the miss is
// accepted.
module lfu_victim_select #(
  parameter int bitsDirect  = 10,
  parameter int sizeCounter = 4,
  parameter int bitsWay     = 2
) (
  input  logic                        clk,
  input  logic                        gen_reset,
  input  logic                        hit_valid,
  input  logic [bitsDirect-bitsWay-1:0] hit_set,
  input  logic [bitsWay-1:0]          hit_way,
  output logic                        hit_ready,
  input  logic                        miss_req,
  input  logic [bitsDirect-bitsWay-1:0] miss_set,
  output logic                        miss_ready,
  output logic                        victim_valid,
  output logic [bitsWay-1:0]          victim_way,
  output logic                        lfu_enable,
  output logic                        lfu_line_reset,
  output logic                        lfu_line_sum,
  output logic [bitsDirect-1:0]       lfu_address,
  output logic                        lfu_count_read,
  input  logic [sizeCounter-1:0]      lfu_count_in
);

  localparam int SET_W = bitsDirect - bitsWay;
  localparam logic [bitsWay-1:0] LAST_WAY = bitsWay'((1 << bitsWay) - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    LAST,
    REPLACE
  } state_e;

  state_e                 state_q,  state_d;
  logic [SET_W-1:0]       set_q,    set_d;
  logic [bitsWay-1:0]     ptr_q,    ptr_d;
  logic [sizeCounter-1:0] min_q,    min_d;
  logic [bitsWay-1:0]     cand_q,   cand_d;
  logic [bitsWay-1:0]     victim_q, victim_d;

  // Next-state logic: miss acceptance, running-minimum scan, victim latch.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d  = state_q;
    set_d    = set_q;
    ptr_d    = ptr_q;
    min_d    = min_q;
    cand_d   = cand_q;
    victim_d = victim_q;
    unique case (state_q)
      IDLE: begin
        // A hit in the same cycle wins; the miss is retried next cycle.
        if (miss_req && !hit_valid) begin
          set_d   = miss_set;
          ptr_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // The count on lfu_count_in belongs to the way read one cycle earlier.
        if (ptr_q != '0) begin
          if (ptr_q == bitsWay'(1) || lfu_count_in < min_q) begin
            min_d  = lfu_count_in;
            cand_d = ptr_q - 1'b1;
          end
        end
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_WAY) begin
          state_d = LAST;
        end
      end
      LAST: begin
        // Strict less-than keeps the lower way on a tie.
        victim_d = (lfu_count_in < min_q) ? LAST_WAY : cand_q;
        state_d  = REPLACE;
      end
      REPLACE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; an aborted miss simply vanishes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (gen_reset) begin
      state_q  <= IDLE;
      set_q    <= '0;
      ptr_q    <= '0;
      min_q    <= '0;
      cand_q   <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      set_q    <= set_d;
      ptr_q    <= ptr_d;
      min_q    <= min_d;
      cand_q   <= cand_d;
      victim_q <= victim_d;
    end
  end

  // Output decode: hits are answered in the same cycle, the rest follows state.
  always_comb begin
    hit_ready      = 1'b0;
    miss_ready     = 1'b0;
    victim_valid   = 1'b0;
    victim_way     = victim_q;
    lfu_enable     = 1'b0;
    lfu_line_reset = 1'b0;
    lfu_line_sum   = 1'b0;
    lfu_address    = '0;
    lfu_count_read = 1'b0;
    unique case (state_q)
      IDLE: begin
        hit_ready  = 1'b1;
        miss_ready = !hit_valid;
        if (hit_valid) begin
          lfu_enable   = 1'b1;
          lfu_line_sum = 1'b1;
          lfu_address  = {hit_set, hit_way};
        end
      end
      SCAN: begin
        lfu_count_read = 1'b1;
        lfu_address    = {set_q, ptr_q};
      end
      REPLACE: begin
        victim_valid   = 1'b1;
        lfu_enable     = 1'b1;
        lfu_line_reset = 1'b1;
        lfu_address    = {set_q, victim_q};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lfu_victim_select.sv
// Testbench for lfu_victim_select: emulates the LFU counter array (registered
// read port, wrap-around increment) and checks every cycle against a
// reference that tracks hit counts per {set,way} and picks victims by argmin.
module tb_lfu_victim_select;

  localparam int BD = 10;
  localparam int SC = 4;
  localparam int BW = 2;
  localparam int SW = BD - BW;

  logic           clk = 1'b0;
  logic           gen_reset = 1'b1;
  logic           hit_valid = 1'b0;
  logic [SW-1:0]  hit_set = '0;
  logic [BW-1:0]  hit_way = '0;
  logic           hit_ready;
  logic           miss_req = 1'b0;
  logic [SW-1:0]  miss_set = '0;
  logic           miss_ready;
  logic           victim_valid;
  logic [BW-1:0]  victim_way;
  logic           lfu_enable;
  logic           lfu_line_reset;
  logic           lfu_line_sum;
  logic [BD-1:0]  lfu_address;
  logic           lfu_count_read;
  logic [SC-1:0]  lfu_count_in = '0;

  lfu_victim_select #(.bitsDirect(BD), .sizeCounter(SC), .bitsWay(BW)) dut (
    .clk(clk), .gen_reset(gen_reset),
    .hit_valid(hit_valid), .hit_set(hit_set), .hit_way(hit_way), .hit_ready(hit_ready),
    .miss_req(miss_req), .miss_set(miss_set), .miss_ready(miss_ready),
    .victim_valid(victim_valid), .victim_way(victim_way),
    .lfu_enable(lfu_enable), .lfu_line_reset(lfu_line_reset), .lfu_line_sum(lfu_line_sum),
    .lfu_address(lfu_address), .lfu_count_read(lfu_count_read), .lfu_count_in(lfu_count_in)
  );

  always #5 clk = ~clk;

  // Counter array emulation: registered read, increment on line_sum, clear on line_reset.
  logic [SC-1:0] mem [0:(1<<BD)-1] = '{default: '0};
  always @(posedge clk) begin
    if (lfu_count_read === 1'b1) lfu_count_in <= mem[lfu_address];
    if (lfu_enable === 1'b1 && lfu_line_sum === 1'b1) mem[lfu_address] <= mem[lfu_address] + 1'b1;
    if (lfu_enable === 1'b1 && lfu_line_reset === 1'b1) mem[lfu_address] <= '0;
  end

  // Reference state
  logic [SC-1:0] ref_cnt [0:(1<<SW)-1][0:(1<<BW)-1] = '{default: '{default: '0}};
  int            busy = 0;      // 0 idle, k = k-th cycle after miss acceptance
  int            m_set = 0;
  int            exp_vic = 0;
  int            last_vic = 0;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t busy=%0d)", tag, got, exp, $time, busy);
    end
  endtask

  function automatic int pick_victim(input int s);
    int best = 0;
    for (int w = 1; w < (1 << BW); w++)
      if (ref_cnt[s][w] < ref_cnt[s][best]) best = w;
    return best;
  endfunction

  function automatic logic [BD-1:0] addr_of(input int s, input int w);
    return {SW'(s), BW'(w)};
  endfunction

  // One clock cycle: drive at negedge, check settled outputs, advance reference.
  task automatic step(input logic rst, input logic hv, input int hs, input int hw,
                      input logic mr, input int ms);
    logic idle;
    @(negedge clk);
    gen_reset = rst;
    hit_valid = hv;
    hit_set   = SW'(hs);
    hit_way   = BW'(hw);
    miss_req  = mr;
    miss_set  = SW'(ms);
    #1;
    idle = (busy == 0);
    check("hit_ready", 32'(hit_ready), 32'(idle));
    check("miss_ready", 32'(miss_ready), 32'(idle && !hv));
    if (idle && hv) begin
      check("hit_sum", 32'(lfu_line_sum), 1);
      check("hit_en", 32'(lfu_enable), 1);
      check("hit_addr", 32'(lfu_address), 32'(addr_of(hs, hw)));
    end else begin
      check("sum_idle", 32'(lfu_line_sum), 0);
    end
    if (busy >= 1 && busy <= 4) begin
      check("scan_read", 32'(lfu_count_read), 1);
      check("scan_addr", 32'(lfu_address), 32'(addr_of(m_set, busy - 1)));
      check("scan_en", 32'(lfu_enable), 0);
    end else begin
      check("read_idle", 32'(lfu_count_read), 0);
    end
    if (busy == 5) check("last_en", 32'(lfu_enable), 0);
    if (busy == 6) begin
      check("vic_valid", 32'(victim_valid), 1);
      check("vic_way", 32'(victim_way), 32'(exp_vic));
      check("vic_reset", 32'(lfu_line_reset), 1);
      check("vic_en", 32'(lfu_enable), 1);
      check("vic_addr", 32'(lfu_address), 32'(addr_of(m_set, exp_vic)));
    end else begin
      check("valid_idle", 32'(victim_valid), 0);
      check("reset_idle", 32'(lfu_line_reset), 0);
      check("way_hold", 32'(victim_way), 32'(last_vic));
    end
    @(posedge clk);
    if (rst) begin
      busy = 0;
      last_vic = 0;
    end else if (busy == 6) begin
      ref_cnt[m_set][exp_vic] = '0;
      last_vic = exp_vic;
      busy = 0;
    end else if (busy > 0) begin
      busy++;
    end else begin
      if (hv) ref_cnt[hs][hw] = ref_cnt[hs][hw] + 1'b1;
      if (mr && !hv) begin
        busy = 1;
        m_set = ms;
        exp_vic = pick_victim(ms);
      end
    end
  endtask

  task automatic idle_cyc();
    step(1'b0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic hit(input int s, input int w);
    step(1'b0, 1'b1, s, w, 1'b0, 0);
  endtask

  task automatic run_miss(input int s, input int want);
    step(1'b0, 1'b0, 0, 0, 1'b1, s);
    for (int i = 0; i < 6; i++) idle_cyc();
    #1;
    check("victim_const", 32'(victim_way), 32'(want));
  endtask

  initial begin
    int r;
    // Raw reset: state is unknown until the first reset edge.
    gen_reset = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state with reset still asserted, then release.
    step(1'b1, 1'b0, 0, 0, 1'b0, 0);

    // 1: all counts zero, set 5 -> way 0, line_reset at address 20
    run_miss(5, 0);

    // 2: set 3 counts {2,3,1,4} -> way 2 twice
    for (int i = 0; i < 2; i++) hit(3, 0);
    for (int i = 0; i < 3; i++) hit(3, 1);
    hit(3, 2);
    for (int i = 0; i < 4; i++) hit(3, 3);
    run_miss(3, 2);
    run_miss(3, 2);

    // 3: ties, set 1 {2,1,1,3} -> way 1; then all 7 -> way 0
    for (int i = 0; i < 2; i++) hit(1, 0);
    hit(1, 1);
    hit(1, 2);
    for (int i = 0; i < 3; i++) hit(1, 3);
    run_miss(1, 1);
    for (int w = 0; w < 4; w++)
      for (int g = 0; g < 16 && ref_cnt[1][w] != 4'd7; g++) hit(1, w);
    run_miss(1, 0);

    // 4: hit and miss together -> hit wins, miss accepted next cycle
    step(1'b0, 1'b1, 2, 3, 1'b1, 2);
    run_miss(2, 0);

    // 5: reset during scan cycle 2 -> no victim, counters untouched
    hit(6, 0);
    step(1'b0, 1'b0, 0, 0, 1'b1, 6);
    idle_cyc();
    idle_cyc();
    step(1'b1, 1'b0, 0, 0, 1'b0, 0);
    for (int i = 0; i < 7; i++) idle_cyc();

    // 6: hits during scan are refused and not counted
    step(1'b0, 1'b0, 0, 0, 1'b1, 2);
    step(1'b0, 1'b1, 2, 0, 1'b0, 0);
    step(1'b0, 1'b1, 2, 1, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2, 2, 1'b0, 0);
    idle_cyc();

    // Randomized traffic on a few sets to get interesting counts
    for (int c = 0; c < 3000; c++) begin
      if (busy == 0) begin
        r = $urandom_range(0, 9);
        step(1'b0, r <= 5 || r == 8, $urandom_range(0, 3), $urandom_range(0, 3),
             r >= 6 && r <= 8, $urandom_range(0, 3));
      end else begin
        step(busy <= 5 && $urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3));
      end
    end
    for (int i = 0; i < 8; i++) idle_cyc();

    // Counter array contents must match the reference counts
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++)
        check("mem", 32'(mem[addr_of(s, w)]), 32'(ref_cnt[s][w]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
